alu_arbiter: RTL and testbench

- Sequencer and round-robin arbiter that shares one 16-bit ALU between two requesters.
- Accepts high-level operations (ADD, SUB, AND, full MUL, full DIV) on a valid/ready interface.
- Issues one or two ALU commands per operation and waits a fixed ALU latency for each.
- Returns a 30-bit result, tagged with the requester ID, on a shared valid/ready response port.

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle for alu_arbiter.
// slave  : arbiter view (drives ready, ALU command and response).
// master : requester/ALU/consumer view.
interface alu_arbiter_if #(
  parameter int unsigned W = 16
);
  logic               req0_valid;
  logic               req0_ready;
  logic [2:0]         req0_op;
  logic [W-1:0]       req0_a;
  logic [W-1:0]       req0_b;

  logic               req1_valid;
  logic               req1_ready;
  logic [2:0]         req1_op;
  logic [W-1:0]       req1_a;
  logic [W-1:0]       req1_b;

  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [2:0]         alu_cmd;
  logic [W-2:0]       alu_res;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [2*(W-1)-1:0] resp_data;
  logic               resp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_res, resp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_cmd,
    output resp_valid, resp_id, resp_data, resp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_res, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_cmd,
    input  resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one W-bit ALU between two requesters.
// Each operation runs as one or two fixed-latency ALU passes and returns a
// tagged {hi, lo} result on a shared response port.
// Optional macro ALU_ARB_STATS_EN adds saturating per-requester/error counters.
module alu_arbiter #(
  parameter int unsigned W       = 16,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  stat_ops0,
  output logic [15:0]  stat_ops1,
  output logic [15:0]  stat_err
`endif
);

  localparam int unsigned RW = W - 1;
  localparam int unsigned DW = 2 * RW;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] CMD_MP0 = 3'd3;
  localparam logic [2:0] CMD_MP1 = 3'd4;
  localparam logic [2:0] CMD_DV0 = 3'd5;
  localparam logic [2:0] CMD_DV1 = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

  // ADD/SUB/AND share their op code with the ALU command
  function automatic logic [2:0] pass1_cmd(input logic [2:0] op);
    case (op)
      OP_MUL:  pass1_cmd = CMD_MP0;
      OP_DIV:  pass1_cmd = CMD_DV0;
      default: pass1_cmd = op;
    endcase
  endfunction

  function automatic logic [2:0] pass2_cmd(input logic [2:0] op);
    pass2_cmd = (op == OP_MUL) ? CMD_MP1 : CMD_DV1;
  endfunction

  function automatic logic two_pass(input logic [2:0] op);
    two_pass = (op == OP_MUL) || (op == OP_DIV);
  endfunction

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [RW-1:0]   hi_q, hi_d;
  logic [RW-1:0]   lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [2:0]      alu_cmd_q, alu_cmd_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_id_q, resp_id_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic            grant_c;
  logic            grant_id_c;
  logic [2:0]      sel_op_c;
  logic [W-1:0]    sel_a_c;
  logic [W-1:0]    sel_b_c;
  logic            hs_c;

  // Arbitration: pointer-favoured requester first, otherwise the other one
  assign grant_c    = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign grant_id_c = ptr_q ? bus.req1_valid : !bus.req0_valid;
  assign sel_op_c   = grant_id_c ? bus.req1_op : bus.req0_op;
  assign sel_a_c    = grant_id_c ? bus.req1_a  : bus.req0_a;
  assign sel_b_c    = grant_id_c ? bus.req1_b  : bus.req0_b;
  assign hs_c       = resp_valid_q && bus.resp_ready;

  assign bus.req0_ready = grant_c && !grant_id_c;
  assign bus.req1_ready = grant_c && grant_id_c;

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

  // Next-state, operand latching and registered-output preparation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (grant_c) begin
          ptr_d = !grant_id_c;
          id_d  = grant_id_c;
          op_d  = sel_op_c;
          a_d   = sel_a_c;
          b_d   = sel_b_c;
          hi_d  = '0;
          lo_d  = '0;
          err_d = 1'b0;
          // Illegal op or zero-magnitude divisor skips the ALU entirely
          if ((sel_op_c > OP_DIV) ||
              ((sel_op_c == OP_DIV) && (sel_b_c[W-1:1] == '0))) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = EXEC1;
          end
        end
      end
      EXEC1: begin
        if (cnt_q == '0) begin
          if (two_pass(op_q)) begin
            hi_d    = bus.alu_res;
            cnt_d   = CNT_LOAD;
            state_d = EXEC2;
          end else begin
            lo_d    = bus.alu_res;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EXEC2: begin
        if (cnt_q == '0) begin
          lo_d    = bus.alu_res;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (hs_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    alu_cmd_d = '0;
    alu_a_d   = '0;
    alu_b_d   = '0;
    if (state_d == EXEC1) begin
      alu_cmd_d = pass1_cmd(op_d);
      alu_a_d   = a_d;
      alu_b_d   = b_d;
    end else if (state_d == EXEC2) begin
      alu_cmd_d = pass2_cmd(op_d);
      alu_a_d   = a_d;
      alu_b_d   = b_d;
    end

    resp_valid_d = (state_d == RESP);
    resp_id_d    = (state_d == RESP) ? id_d  : 1'b0;
    resp_err_d   = (state_d == RESP) ? err_d : 1'b0;
    resp_data_d  = (state_d == RESP) ? {hi_d, lo_d} : '0;
  end

  // State, operand and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] ops0_q;
  logic [15:0] ops1_q;
  logic [15:0] err_cnt_q;

  // Saturating completion counters, stepped on each response handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops0_q    <= '0;
      ops1_q    <= '0;
      err_cnt_q <= '0;
    end else if (hs_c) begin
      if (resp_err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (resp_id_q) begin
        if (ops1_q != 16'hFFFF) ops1_q <= ops1_q + 16'd1;
      end else begin
        if (ops0_q != 16'hFFFF) ops0_q <= ops0_q + 16'd1;
      end
    end
  end

  assign stat_ops0 = ops0_q;
  assign stat_ops1 = ops1_q;
  assign stat_err  = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed operations push expected
// responses at grant time; a negedge monitor pops and compares on handshake.
module tb_alu_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;

  typedef struct {
    bit          id;
    logic [29:0] data;
    bit          err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  exp_t       exp_q[$];
  bit         grant_q[$];
  logic [2:0] tr_q[$];
  bit         tr_en = 1'b0;
  bit         rv_prev = 1'b0;
  int         rise_cyc = 0;
  exp_t       e;
  int         held = 0;
  logic [34:0] prev_alu = '1;
  logic [34:0] cur_alu;

  alu_arbiter_if #(.W(W)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops0, stat_ops1, stat_err;
`endif

  alu_arbiter #(.W(W), .ALU_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops0 (stat_ops0),
    .stat_ops1 (stat_ops1),
    .stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] alu_f(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] s;
    p = 32'(a) * 32'(b);
    case (c)
      3'd0: s = a + b;
      3'd1: s = a - b;
      3'd2: s = a & b;
      3'd3: s = p[30:15];
      3'd4: s = {1'b0, p[14:0]};
      3'd5: s = (b != 16'd0) ? a / b : 16'd0;
      3'd6: s = (b != 16'd0) ? a % b : 16'd0;
      default: s = 16'h0;
    endcase
    return s[14:0];
  endfunction

  // ALU model: result is only correct once the command has been held LAT cycles
  always @(negedge clk) begin
    cur_alu = {bus.alu_cmd, bus.alu_a, bus.alu_b};
    if (cur_alu == prev_alu) held = held + 1;
    else held = 1;
    prev_alu = cur_alu;
    bus.alu_res = (held >= int'(LAT)) ? alu_f(bus.alu_cmd, bus.alu_a, bus.alu_b) : 15'h2AAA;
  end

  // Trace of active ALU commands
  always @(negedge clk) begin
    if (tr_en && (bus.alu_cmd != 3'd0 || bus.alu_a != 16'd0 || bus.alu_b != 16'd0))
      tr_q.push_back(bus.alu_cmd);
  end

  // Response monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid && !rv_prev) rise_cyc = cyc;
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_resp: got id %0d data %0h err %0d, none expected",
                   bus.resp_id, bus.resp_data, bus.resp_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_id",      64'(bus.resp_id),   64'(e.id));
          check("resp_data",    64'(bus.resp_data), 64'(e.data));
          check("resp_err",     64'(bus.resp_err),  64'(e.err));
          check("resp_latency", 64'(rise_cyc),      64'(e.due));
        end
      end
    end
    rv_prev = bus.resp_valid;
  end

  task automatic drive(input bit id, input bit v, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Call at posedge+1; returns one cycle after grant with valid dropped
  task automatic issue(input bit id, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [29:0] ed, input bit ee);
    int  lat;
    bit  got;
    exp_t x;
    lat = ee ? 1 : ((op == 3'd3 || op == 3'd4) ? 1 + 2 * int'(LAT) : 1 + int'(LAT));
    drive(id, 1'b1, op, a, b);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        check("dual_ready", 64'(id ? bus.req0_ready : bus.req1_ready), 64'd0);
        x.id = id; x.data = ed; x.err = ee; x.due = cyc + lat;
        exp_q.push_back(x);
        grant_q.push_back(id);
      end
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL grant_timeout: requester %0d never granted", id);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, 3'd0, 16'd0, 16'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [2:0] mul_seq [4] = '{3'd3, 3'd3, 3'd4, 3'd4};

  initial begin
    logic [29:0] cap_data;
    logic        cap_id, cap_err;
    bit          got;

    drive(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1'b1, 1'b0, 3'd0, 16'd0, 16'd0);
    bus.resp_ready = 1'b1;
    bus.alu_res = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data",  64'(bus.resp_data),  64'd0);
    check("rst_resp_err",   64'(bus.resp_err),   64'd0);
    check("rst_alu_cmd",    64'(bus.alu_cmd),    64'd0);
    check("rst_alu_a",      64'(bus.alu_a),      64'd0);
    check("rst_ready",      64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Both requesters continuously valid: grants alternate starting at 0
    grant_q.delete();
    fork
      begin issue(1'b0, 3'd0, 16'd1, 16'd2, 30'h3, 1'b0);
            issue(1'b0, 3'd0, 16'd4, 16'd5, 30'h9, 1'b0); end
      begin issue(1'b1, 3'd0, 16'h10, 16'h20, 30'h30, 1'b0);
            issue(1'b1, 3'd0, 16'h40, 16'h1, 30'h41, 1'b0); end
    join
    drain();
    check("alt_count", 64'(grant_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("alt_grant", 64'((grant_q.size() > i) ? grant_q[i] : 1'bx), 64'(i % 2));

    // ADD: command held exactly LAT cycles
    tr_q.delete(); tr_en = 1'b1;
    issue(1'b0, 3'd0, 16'd2, 16'd3, 30'h5, 1'b0);
    drain(); tr_en = 1'b0;
    check("add_alu_cycles", 64'(tr_q.size()), 64'(LAT));
    foreach (tr_q[i]) check("add_alu_cmd", 64'(tr_q[i]), 64'd0);

    issue(1'b0, 3'd1, 16'd10, 16'd3, 30'h7, 1'b0);
    issue(1'b1, 3'd2, 16'hF0F0, 16'h0FF0, 30'hF0, 1'b0);
    drain();

    // MUL on req1: 255*257 = 0xFFFF -> hi 1, lo 7FFF
    tr_q.delete(); tr_en = 1'b1;
    issue(1'b1, 3'd3, 16'd255, 16'd257, {15'h1, 15'h7FFF}, 1'b0);
    drain(); tr_en = 1'b0;
    check("mul_alu_cycles", 64'(tr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("mul_alu_seq", 64'((tr_q.size() > i) ? tr_q[i] : 3'd7), 64'(mul_seq[i]));

    // DIV 100/7 -> quotient 14, remainder 2
    issue(1'b0, 3'd4, 16'd100, 16'd7, {15'd14, 15'd2}, 1'b0);
    drain();

    // Error paths: zero-magnitude divisor and illegal ops, no ALU activity
    tr_q.delete(); tr_en = 1'b1;
    issue(1'b0, 3'd4, 16'd50, 16'h0001, 30'h0, 1'b1);
    issue(1'b0, 3'd6, 16'd3, 16'd4, 30'h0, 1'b1);
    issue(1'b1, 3'd7, 16'd9, 16'd9, 30'h0, 1'b1);
    drain(); tr_en = 1'b0;
    check("err_alu_idle", 64'(tr_q.size()), 64'd0);

    // Response backpressure: fields hold and req1 is blocked
    bus.resp_ready = 1'b0;
    fork issue(1'b0, 3'd0, 16'h11, 16'h22, 30'h33, 1'b0); join_none
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.resp_valid;
    end
    check("stall_resp_seen", 64'(got), 64'd1);
    cap_data = bus.resp_data; cap_id = bus.resp_id; cap_err = bus.resp_err;
    @(posedge clk); #1;
    fork issue(1'b1, 3'd0, 16'd1, 16'd1, 30'h2, 1'b0); join_none
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.resp_valid), 64'd1);
      check("stall_data",  64'(bus.resp_data),  64'(cap_data));
      check("stall_id",    64'({bus.resp_id, bus.resp_err}), 64'({cap_id, cap_err}));
      check("stall_req1_blocked", 64'(bus.req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    wait fork;
    drain();

    // Reset during EXEC2 of a DIV on req0
    drive(1'b0, 1'b1, 3'd4, 16'd1000, 16'd10);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.req0_ready;
    end
    check("rst_div_granted", 64'(got), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
    repeat (LAT + 1) @(negedge clk);
    check("rst_in_exec2", 64'(bus.alu_cmd), 64'd6);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_alu",  64'({bus.alu_cmd, bus.alu_a, bus.alu_b}), 64'd0);
    check("rst_mid_resp", 64'({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    grant_q.delete();
    fork
      issue(1'b0, 3'd0, 16'd5, 16'd6, 30'hB, 1'b0);
      issue(1'b1, 3'd0, 16'd7, 16'd8, 30'hF, 1'b0);
    join
    drain();
    check("post_rst_first_grant", 64'((grant_q.size() > 0) ? grant_q[0] : 1'b1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
